// File: rtl/fpu_addsub_pkg.sv
// Shared definitions for the sliced wide add/sub sequencer.
package fpu_addsub_pkg;

  localparam int SLICE_W = 11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Width of a counter that indexes 0..slices-1 (at least one bit).
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/fpu_wide_addsub_seq_padder11.sv
// 11-bit parallel-prefix (Kogge-Stone) adder with carry in/out.
module padder11 (
  input  logic [10:0] A,
  input  logic [10:0] B,
  input  logic        Cin,
  output logic [10:0] S,
  output logic        Cout
);

  logic [11:0] g;
  logic [11:0] p;
  logic [11:0] g_nxt;
  logic [11:0] p_nxt;

  // Position 0 carries Cin, so the prefix result at i is the carry into bit i.
  always_comb begin
    g     = {A & B, Cin};
    p     = {A ^ B, 1'b0};
    g_nxt = g;
    p_nxt = p;
    for (int d = 1; d < 12; d = d * 2) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = d; i < 12; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-d]);
        p_nxt[i] = p[i] & p[i-d];
      end
      g = g_nxt;
      p = p_nxt;
    end
    S    = (A ^ B) ^ g[10:0];
    Cout = g[11];
  end

endmodule

// File: rtl/fpu_wide_addsub_seq.sv
// Wide two's-complement add/sub built by iterating one 11-bit adder slice
// LSB-first with a registered carry, behind valid/ready handshakes.
module fpu_wide_addsub_seq
  import fpu_addsub_pkg::*;
#(
  parameter int SLICES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*SLICES-1:0] in_a,
  input  logic [SLICE_W*SLICES-1:0] in_b,
  input  logic                      in_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*SLICES-1:0] out_sum,
  output logic                      out_cout,
  output logic                      out_ovf
);

  localparam int W  = SLICE_W * SLICES;
  localparam int CW = cnt_width(SLICES);
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  state_t state;
  state_t state_next;

  logic [W-1:0]       a;
  logic [W-1:0]       b;
  logic               carry;
  logic [CW-1:0]      slice_cnt;
  logic [SLICE_W-1:0] a_sl [SLICES];
  logic [SLICE_W-1:0] b_sl [SLICES];
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] s;
  logic               cout;
  logic [SLICES-1:0]  wr_en;
  logic               accept;
  logic               last;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;
  assign last     = (slice_cnt == LAST);

  genvar gi;
  generate
    for (gi = 0; gi < SLICES; gi++) begin : g_slice
      assign a_sl[gi]  = a[gi*SLICE_W +: SLICE_W];
      assign b_sl[gi]  = b[gi*SLICE_W +: SLICE_W];
      assign wr_en[gi] = (state == RUN) && (slice_cnt == CW'(gi));
    end
  endgenerate

  assign sa = a_sl[slice_cnt];
  assign sb = b_sl[slice_cnt];

  padder11 u_adder (
    .A   (sa),
    .B   (sb),
    .Cin (carry),
    .S   (s),
    .Cout(cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      carry     <= 1'b0;
      slice_cnt <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      if (accept) begin
        a         <= in_a;
        b         <= in_sub ? ~in_b : in_b;
        carry     <= in_sub;
        slice_cnt <= '0;
      end
      if (state == RUN) begin
        carry     <= cout;
        slice_cnt <= slice_cnt + 1'b1;
        for (int i = 0; i < SLICES; i++) begin
          if (wr_en[i]) out_sum[i*SLICE_W +: SLICE_W] <= s;
        end
        // The top slice's sum bit is the result MSB, so overflow is known now.
        if (last) begin
          out_cout <= cout;
          out_ovf  <= (a[W-1] == b[W-1]) & (s[SLICE_W-1] != a[W-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_wide_addsub_seq.sv
// Directed and randomised checks of the sliced wide add/sub sequencer.
module tb_fpu_wide_addsub_seq;

  localparam int W = 44;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  fpu_wide_addsub_seq #(.SLICES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: sum, carry-out and signed overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] sum, output logic c, output logic o);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
    sum  = full[W-1:0];
    c    = full[W];
    o    = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
  endtask

  // Called at a negedge in IDLE; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output int lat);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] s, input logic c, input logic o);
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_sum"},   64'(out_sum),   64'(s));
    check({tag, "_cout"},  64'(out_cout),  64'(c));
    check({tag, "_ovf"},   64'(out_ovf),   64'(o));
    $display("op %s: sum=%h cout=%0b ovf=%0b", tag, out_sum, out_cout, out_ovf);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", 64'(in_ready), 64'(1'b1));
    check("release_out_valid", 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    int lat;
    int prev;
    bit seen;
    logic [W-1:0] ea, eb, es, hold_sum;
    logic ec, eo, es_sub;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_sum",   64'(out_sum),   64'(0));
    check("rst_out_cout",  64'(out_cout),  64'(1'b0));
    check("rst_out_ovf",   64'(out_ovf),   64'(1'b0));
    check("rst_in_ready",  64'(in_ready),  64'(1'b0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);

    run_op(44'h000000007FF, 44'h00000000001, 1'b0, lat);
    check("slice_carry_latency", 64'(lat), 64'(4));
    check_res("slice_carry", 44'h00000000800, 1'b0, 1'b0);
    release_out();

    run_op(44'hFFFFFFFFFFF, 44'h00000000001, 1'b0, lat);
    check_res("full_ripple", 44'h00000000000, 1'b1, 1'b0);
    release_out();

    run_op(44'd5, 44'd7, 1'b1, lat);
    check_res("sub_5_7", 44'hFFFFFFFFFFE, 1'b0, 1'b0);
    release_out();

    run_op(44'h7FFFFFFFFFF, 44'd1, 1'b0, lat);
    check_res("add_ovf", 44'h80000000000, 1'b0, 1'b1);
    release_out();

    run_op(44'h80000000000, 44'd1, 1'b1, lat);
    check_res("sub_ovf", 44'h7FFFFFFFFFF, 1'b1, 1'b1);
    release_out();

    run_op(44'h00000000123, 44'h00000000123, 1'b1, lat);
    check_res("sub_equal", 44'h0, 1'b1, 1'b0);
    release_out();

    // Backpressure: result must hold while new requests are presented.
    run_op(44'h123456789AB, 44'h0FEDCBA9876, 1'b0, lat);
    model(44'h123456789AB, 44'h0FEDCBA9876, 1'b0, es, ec, eo);
    check_res("bp_first", es, ec, eo);
    hold_sum = out_sum;
    in_a = 44'h00000ABCDEF; in_b = 44'h00000012345; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'(1'b1));
      check("bp_in_ready", 64'(in_ready), 64'(1'b0));
      check("bp_sum_stable", 64'(out_sum), 64'(hold_sum));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_ready_back", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    model(44'h00000ABCDEF, 44'h00000012345, 1'b1, es, ec, eo);
    check_res("bp_second", es, ec, eo);
    release_out();

    // Reset during slice 2: no result may appear for the aborted request.
    in_a = 44'h00000000FFF; in_b = 44'h00000000FFF; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 64'(in_ready), 64'(1'b0));
    check("midrst_out_valid", 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_high", 64'(in_ready), 64'(1'b1));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'(1'b0));
    run_op(44'd3, 44'd4, 1'b0, lat);
    check("midrst_after_latency", 64'(lat), 64'(4));
    check_res("midrst_3_plus_4", 44'd7, 1'b0, 1'b0);
    release_out();

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 20; k++) begin
      ea = W'({$urandom, $urandom});
      eb = W'({$urandom, $urandom});
      es_sub = 1'($urandom_range(0, 1));
      check("b2b_in_ready", 64'(in_ready), 64'(1'b1));
      in_a = ea; in_b = eb; in_sub = es_sub; in_valid = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      model(ea, eb, es_sub, es, ec, eo);
      check_res($sformatf("b2b_%0d", k), es, ec, eo);
      if (k > 0) check("b2b_period", 64'(cyc - prev), 64'(6));
      prev = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_wide_addsub_seq.md
# fpu_wide_addsub_seq

Multi-cycle sequencer that performs wide two's-complement add/subtract by time-multiplexing one 11-bit prefix adder slice. It sits beside the FPU add/sub datapath and handles mantissa-width operations where area matters more than throughput. The adder is iterated least-significant slice first, with a registered carry between slices. Operands are accepted and results are returned over valid/ready handshakes.

## Interface
- `SLICES`, default 4: number of 11-bit slices. Operand width `W = 11*SLICES` (44 by default). Legal range 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block can accept a request.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_sub` in 1: 1 = A−B, 0 = A+B.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out W: result, modulo 2^W.
- `out_cout` out 1: carry out of the MSB. For subtract, 1 means no borrow (A ≥ B unsigned).
- `out_ovf` out 1: signed overflow.

## Operation
- **FSM states:**
  - IDLE → RUN on `in_valid & in_ready`.
  - RUN → RUN while `slice_cnt < SLICES-1`.
  - RUN → DONE after slice `SLICES-1`.
  - DONE → IDLE on `out_valid & out_ready`.
- **Accept:** latch `a = in_a` and `b = in_sub ? ~in_b : in_b`. Set `carry = in_sub` and `slice_cnt = 0`.
- **RUN cycle i:**
  - Adder inputs: `A = a[11i+10:11i]`, `B = b[11i+10:11i]`, `Cin = carry`.
  - `result[11i+10:11i] <= S`, `carry <= Cout`, `slice_cnt <= i+1`.
- **Entering DONE:**
  - `out_cout = final carry`.
  - `out_ovf = (a[W-1] == b[W-1]) & (result[W-1] != a[W-1])`, computed on the inverted B for subtract.
  - `out_sum = result`.
- **Handshake signals:**
  - `in_ready = (state == IDLE) & ~rst`.
  - `out_valid = (state == DONE)`.
  - `in_valid` is ignored outside IDLE.
- **Output stability:** `out_sum`, `out_cout` and `out_ovf` hold stable throughout DONE. They are don't-care whenever `out_valid = 0`.
- **Reset values:** state IDLE, `out_valid = 0`, `out_sum = 0`, `out_cout = 0`, `out_ovf = 0`, `carry = 0`, `slice_cnt = 0`, operand registers 0.
- **Reset mid-operation:** aborts immediately. No `out_valid` is ever produced for an aborted request.
- **Backpressure:** `out_ready` low in DONE holds the result indefinitely and keeps `in_ready = 0`.

## Timing
- All outputs are registered, except `in_ready`, which is decoded from registered state.
- **Latency:** the accept edge is E0. RUN edges are E1..E_SLICES. `out_valid` rises after E_SLICES, i.e. `SLICES` cycles after acceptance (4 by default).
- **Throughput:** at best one operation per `SLICES + 2` cycles (accept, `SLICES` RUN cycles, DONE with `out_ready = 1`). `in_ready` returns high the cycle after the output handshake.
- **Carry path:** one adder slice plus the carry register per cycle. There is no combinational path from `in_*` to `out_*`.

## Structure
- **Shared package `fpu_addsub_pkg`:**
  - Constant `SLICE_W = 11`.
  - State enum `{IDLE, RUN, DONE}`.
  - Helper function computing `$clog2(SLICES)` for `slice_cnt` width.
- **One sub-module:** the existing `padder11` 11-bit prefix adder (ports A, B, Cin, S, Cout), instantiated once.
- **Slice select:** operand slice muxing and result slice write-enable are decoded from `slice_cnt` in this block.

## Test plan
- **Slice carry:** `a = 0x000000007FF`, `b = 0x00000000001`, add → `out_sum = 0x00000000800`, `cout = 0`, `ovf = 0`. `out_valid` rises exactly 4 cycles after the accept edge.
- **Full ripple:** `a = 0xFFFFFFFFFFF`, `b = 0x00000000001`, add → `out_sum = 0x00000000000`, `cout = 1`, `ovf = 0`.
- **Subtract and overflow:**
  - `a = 5`, `b = 7`, sub → `out_sum = 0xFFFFFFFFFFE`, `cout = 0`, `ovf = 0`.
  - `a = 0x7FFFFFFFFFF`, `b = 1`, add → `out_sum = 0x80000000000`, `ovf = 1`.
- **Backpressure:** hold `out_ready = 0` for 10 cycles in DONE while driving `in_valid = 1` with new operands → `out_*` stable, `in_ready = 0`, new operands not latched. After `out_ready` pulses, the next request is accepted and its result is correct.
- **Reset mid-RUN:** assert `rst` during slice 2 → `out_valid` stays 0, and `in_ready = 1` the first cycle after `rst` deasserts. A subsequent add of `3 + 4` returns 7.
- **Back-to-back:** 20 random add/sub requests with `in_valid` and `out_ready` held at 1 → one result every 6 cycles. All sums, carries and overflows match a reference model.
